// File: rtl/lfsr_bist_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_bist_pkg
// Shared definitions for the LFSR-based memory BIST sequencer:
//   - bist_state_e  : sequencer state encoding (the *_INV states are only
//                     reachable when LFSR_BIST_INV_PASS_EN is defined)
//   - LFSR_TAPS     : feedback taps of the 8-bit Fibonacci LFSR (bits 7,5,4,3)
//   - SEED_ZERO_SUB : seed used in place of the lock-up value 8'h00
//   - LFSR_RESET    : LFSR register value after reset
//   - lfsr_next()   : one shift-left step of the LFSR
//   - seed_fix()    : applies the zero-seed substitution
// ---------------------------------------------------------------------------
package lfsr_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_READ      = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_DONE      = 3'd4,
        ST_WRITE_INV = 3'd5,
        ST_READ_INV  = 3'd6
    } bist_state_e;

    localparam logic [7:0] LFSR_TAPS     = 8'hB8;
    localparam logic [7:0] SEED_ZERO_SUB = 8'h01;
    localparam logic [7:0] LFSR_RESET    = 8'h01;

    // Shift left, feedback is the XOR of the tapped bits.
    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], ^(q & LFSR_TAPS)};
    endfunction

    // An all-zero LFSR never leaves zero, so that seed is replaced.
    function automatic logic [7:0] seed_fix(input logic [7:0] s);
        return (s == 8'h00) ? SEED_ZERO_SUB : s;
    endfunction

endpackage

// File: rtl/lfsr_8b_ld.sv
// ---------------------------------------------------------------------------
// lfsr_8b_ld
// 8-bit Fibonacci LFSR with synchronous seed load.
// Ports:
//   clk   : clock, state on rising edge
//   rstn  : asynchronous active-low reset, q returns to 8'h01
//   load  : load seed (zero seed substituted), has priority over en
//   en    : advance one LFSR step
//   seed  : seed value
//   q     : current LFSR value
// ---------------------------------------------------------------------------
module lfsr_8b_ld
    import lfsr_bist_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       load,
    input  logic       en,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    // Next LFSR value: load beats advance.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = seed_fix(seed);
        end else if (en) begin
            q_d = lfsr_next(q_q);
        end else begin
            q_d = q_q;
        end
    end

    // LFSR state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_q <= LFSR_RESET;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/lfsr_bist_ctrl.sv
// ---------------------------------------------------------------------------
// lfsr_bist_ctrl
// Pseudo-random memory self-test: writes an LFSR pattern to every address of a
// single-port synchronous SRAM, regenerates it from the same seed, reads back
// and compares. Reports pass/fail, first failing address and a saturating
// mismatch count.
//
// Optional build macro LFSR_BIST_INV_PASS_EN: adds WRITE_INV/READ_INV phases
// that repeat the test with inverted data (busy length 4*2**AW+1 cycles).
//
// Ports:
//   clk, rstn          : clock, asynchronous active-low reset
//   start, seed        : run request (IDLE/DONE only) and its LFSR seed
//   busy, done, pass   : status; pass valid only while done=1
//   fail_addr, fail_cnt: first mismatching address, saturating mismatch count
//   mem_cs, mem_we, mem_addr, mem_wdata : SRAM command (we=1 write)
//   mem_rdata          : SRAM read data, one cycle after a read command
// ---------------------------------------------------------------------------
module lfsr_bist_ctrl
    import lfsr_bist_pkg::*;
#(
    parameter int AW  = 4,
    parameter int FCW = 8
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           start,
    input  logic [7:0]     seed,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [AW-1:0]  fail_addr,
    output logic [FCW-1:0] fail_cnt,
    output logic           mem_cs,
    output logic           mem_we,
    output logic [AW-1:0]  mem_addr,
    output logic [7:0]     mem_wdata,
    input  logic [7:0]     mem_rdata
);

    localparam logic [AW-1:0]  ADDR_LAST = {AW{1'b1}};
    localparam logic [AW-1:0]  ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [FCW-1:0] CNT_MAX   = {FCW{1'b1}};
    localparam logic [FCW-1:0] CNT_ONE   = {{(FCW-1){1'b0}}, 1'b1};

    bist_state_e    state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [7:0]     seed_q, seed_d;
    logic [7:0]     exp_q, exp_d;
    logic [AW-1:0]  exp_addr_q, exp_addr_d;
    logic           exp_v_q, exp_v_d;
    logic [FCW-1:0] fail_cnt_q, fail_cnt_d;
    logic [AW-1:0]  fail_addr_q, fail_addr_d;
    logic           done_q, done_d;
    logic           pass_q, pass_d;

    logic           lfsr_load_s;
    logic           lfsr_en_s;
    logic [7:0]     lfsr_seed_s;
    logic [7:0]     lfsr_q_s;
    logic           accept_s;
    logic           last_s;
    logic           is_write_s;
    logic           is_read_s;
    logic           inv_s;
    logic [7:0]     pattern_s;
    logic           mismatch_s;

    lfsr_8b_ld u_lfsr (
        .clk  (clk),
        .rstn (rstn),
        .load (lfsr_load_s),
        .en   (lfsr_en_s),
        .seed (lfsr_seed_s),
        .q    (lfsr_q_s)
    );

    assign accept_s = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;
    assign last_s   = (addr_q == ADDR_LAST);

`ifdef LFSR_BIST_INV_PASS_EN
    assign is_write_s = (state_q == ST_WRITE) || (state_q == ST_WRITE_INV);
    assign is_read_s  = (state_q == ST_READ)  || (state_q == ST_READ_INV);
    assign inv_s      = (state_q == ST_WRITE_INV) || (state_q == ST_READ_INV);
`else
    assign is_write_s = (state_q == ST_WRITE);
    assign is_read_s  = (state_q == ST_READ);
    assign inv_s      = 1'b0;
`endif

    // The pipe stores the data actually written, so the inverted passes
    // compare against ~q without a separate polarity bit in the pipe.
    assign pattern_s  = inv_s ? ~lfsr_q_s : lfsr_q_s;
    assign mismatch_s = exp_v_q && (mem_rdata != exp_q);

    // Sequencer next state, address counter, LFSR control and status.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        seed_d      = seed_q;
        lfsr_load_s = 1'b0;
        lfsr_en_s   = 1'b0;
        lfsr_seed_s = seed_q;
        done_d      = done_q;
        pass_d      = pass_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_WRITE;
                    addr_d      = {AW{1'b0}};
                    seed_d      = seed;
                    lfsr_load_s = 1'b1;
                    lfsr_seed_s = seed;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_WRITE: begin
                lfsr_en_s = 1'b1;
                if (last_s) begin
                    lfsr_load_s = 1'b1;
                    addr_d      = {AW{1'b0}};
                    state_d     = ST_READ;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            ST_READ: begin
                lfsr_en_s = 1'b1;
                if (last_s) begin
                    addr_d = {AW{1'b0}};
`ifdef LFSR_BIST_INV_PASS_EN
                    lfsr_load_s = 1'b1;
                    state_d     = ST_WRITE_INV;
`else
                    state_d = ST_DRAIN;
`endif
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
`ifdef LFSR_BIST_INV_PASS_EN
            ST_WRITE_INV: begin
                lfsr_en_s = 1'b1;
                if (last_s) begin
                    lfsr_load_s = 1'b1;
                    addr_d      = {AW{1'b0}};
                    state_d     = ST_READ_INV;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            ST_READ_INV: begin
                lfsr_en_s = 1'b1;
                if (last_s) begin
                    addr_d  = {AW{1'b0}};
                    state_d = ST_DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
`endif
            ST_DRAIN: begin
                // Includes the final compare completing in this cycle.
                state_d = ST_DONE;
                done_d  = 1'b1;
                pass_d  = (fail_cnt_d == {FCW{1'b0}});
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // One-stage compare pipe aligned with the SRAM read latency.
    always_comb begin
        exp_v_d    = is_read_s;
        exp_d      = exp_q;
        exp_addr_d = exp_addr_q;
        if (is_read_s) begin
            exp_d      = pattern_s;
            exp_addr_d = addr_q;
        end else begin
            exp_d      = exp_q;
            exp_addr_d = exp_addr_q;
        end
    end

    // Mismatch accounting; a zero count marks the first mismatch of a run.
    always_comb begin
        fail_cnt_d  = fail_cnt_q;
        fail_addr_d = fail_addr_q;
        if (accept_s) begin
            fail_cnt_d  = {FCW{1'b0}};
            fail_addr_d = {AW{1'b0}};
        end else if (mismatch_s) begin
            if (fail_cnt_q != CNT_MAX) begin
                fail_cnt_d = fail_cnt_q + CNT_ONE;
            end else begin
                fail_cnt_d = fail_cnt_q;
            end
            if (fail_cnt_q == {FCW{1'b0}}) begin
                fail_addr_d = exp_addr_q;
            end else begin
                fail_addr_d = fail_addr_q;
            end
        end else begin
            fail_cnt_d  = fail_cnt_q;
            fail_addr_d = fail_addr_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            addr_q      <= {AW{1'b0}};
            seed_q      <= 8'h00;
            exp_q       <= 8'h00;
            exp_addr_q  <= {AW{1'b0}};
            exp_v_q     <= 1'b0;
            fail_cnt_q  <= {FCW{1'b0}};
            fail_addr_q <= {AW{1'b0}};
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            seed_q      <= seed_d;
            exp_q       <= exp_d;
            exp_addr_q  <= exp_addr_d;
            exp_v_q     <= exp_v_d;
            fail_cnt_q  <= fail_cnt_d;
            fail_addr_q <= fail_addr_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    // SRAM command decoded from registered state; idle states drive zeros.
    always_comb begin
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {AW{1'b0}};
        mem_wdata = 8'h00;
        if (is_write_s) begin
            mem_cs    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = pattern_s;
        end else if (is_read_s) begin
            mem_cs   = 1'b1;
            mem_addr = addr_q;
        end else begin
            mem_cs = 1'b0;
        end
    end

    assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_addr = fail_addr_q;
    assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_lfsr_bist_ctrl.sv
module tb_lfsr_bist_ctrl;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // DUT A: AW=4, FCW=8
    logic       start_a = 1'b0;
    logic [7:0] seed_a  = 8'h00;
    logic       busy_a, done_a, pass_a;
    logic [3:0] fail_addr_a, mem_addr_a;
    logic [7:0] fail_cnt_a, mem_wdata_a;
    logic       mem_cs_a, mem_we_a;
    logic [7:0] mem_rdata_a = 8'h00;
    logic [7:0] mem_a [16];
    logic [15:0] bad_a = 16'h0000;

    // DUT B: AW=5, FCW=4, every read corrupted
    logic       start_b = 1'b0;
    logic [7:0] seed_b  = 8'h00;
    logic       busy_b, done_b, pass_b;
    logic [4:0] fail_addr_b, mem_addr_b;
    logic [3:0] fail_cnt_b;
    logic [7:0] mem_wdata_b;
    logic       mem_cs_b, mem_we_b;
    logic [7:0] mem_rdata_b = 8'h00;
    logic [7:0] mem_b [32];

    lfsr_bist_ctrl #(.AW(4), .FCW(8)) u_dut_a (
        .clk(clk), .rstn(rstn), .start(start_a), .seed(seed_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .fail_addr(fail_addr_a), .fail_cnt(fail_cnt_a),
        .mem_cs(mem_cs_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
    );

    lfsr_bist_ctrl #(.AW(5), .FCW(4)) u_dut_b (
        .clk(clk), .rstn(rstn), .start(start_b), .seed(seed_b),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .fail_addr(fail_addr_b), .fail_cnt(fail_cnt_b),
        .mem_cs(mem_cs_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
    );

    // Synchronous SRAM model A with per-address stuck-at-zero read faults.
    always @(posedge clk) begin
        if (mem_cs_a && mem_we_a) mem_a[mem_addr_a] <= mem_wdata_a;
        if (mem_cs_a && !mem_we_a) mem_rdata_a <= bad_a[mem_addr_a] ? 8'h00 : mem_a[mem_addr_a];
    end

    // Synchronous SRAM model B returning inverted data on every read.
    always @(posedge clk) begin
        if (mem_cs_b && mem_we_b) mem_b[mem_addr_b] <= mem_wdata_b;
        if (mem_cs_b && !mem_we_b) mem_rdata_b <= ~mem_b[mem_addr_b];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Start a run on DUT A and count busy cycles until done (bounded).
    task automatic run_a(input logic [7:0] s, output int busy_n);
        int guard;
        @(negedge clk);
        seed_a  = s;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check_val("a_start_clears_done", 32'(done_a), 32'd0);
        busy_n = 0;
        guard  = 0;
        while (!done_a && guard < 400) begin
            if (busy_a) busy_n++;
            guard++;
            @(negedge clk);
        end
        check_val("a_run_done", 32'(done_a), 32'd1);
    endtask

    logic [7:0] exp_seq [6];
    int nb;

    initial begin
        exp_seq[0] = 8'h01; exp_seq[1] = 8'h02; exp_seq[2] = 8'h04;
        exp_seq[3] = 8'h08; exp_seq[4] = 8'h11; exp_seq[5] = 8'h23;

        // Reset held for 15 ns
        #1;
        check_val("rst_busy",      32'(busy_a),      32'd0);
        check_val("rst_done",      32'(done_a),      32'd0);
        check_val("rst_pass",      32'(pass_a),      32'd0);
        check_val("rst_fail_addr", 32'(fail_addr_a), 32'd0);
        check_val("rst_fail_cnt",  32'(fail_cnt_a),  32'd0);
        check_val("rst_mem_cs",    32'(mem_cs_a),    32'd0);
        check_val("rst_mem_we",    32'(mem_we_a),    32'd0);
        check_val("rst_mem_addr",  32'(mem_addr_a),  32'd0);
        check_val("rst_mem_wdata", 32'(mem_wdata_a), 32'd0);
        check_val("rst_b_fail_cnt", 32'(fail_cnt_b), 32'd0);
        #14;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("idle_no_cs", 32'({mem_cs_a, mem_cs_b, busy_a, done_a}), 32'd0);
        end

        // Ideal memory, seed 01
        run_a(8'h01, nb);
        check_val("s01_busy_cycles", 32'(nb), 32'd33);
        check_val("s01_pass",     32'(pass_a),     32'd1);
        check_val("s01_fail_cnt", 32'(fail_cnt_a), 32'd0);
        for (int i = 0; i < 6; i++) check_val("s01_wdata", 32'(mem_a[i]), 32'(exp_seq[i]));
        check_val("s01_wdata_a9", 32'(mem_a[9]), 32'h38);
        repeat (3) @(negedge clk);
        check_val("done_held",   32'(done_a), 32'd1);
        check_val("pass_held",   32'(pass_a), 32'd1);
        check_val("done_idle_cs", 32'({mem_cs_a, mem_we_a, mem_addr_a, mem_wdata_a}), 32'd0);

        // Read faults at addresses 5 and 9
        bad_a = 16'h0220;
        run_a(8'h01, nb);
        check_val("flt_busy_cycles", 32'(nb), 32'd33);
        check_val("flt_pass",      32'(pass_a),      32'd0);
        check_val("flt_fail_cnt",  32'(fail_cnt_a),  32'd2);
        check_val("flt_fail_addr", 32'(fail_addr_a), 32'd5);
        bad_a = 16'h0000;

        // Different seed, then zero seed
        run_a(8'hA5, nb);
        check_val("sA5_pass",  32'(pass_a),   32'd1);
        check_val("sA5_fail_cnt", 32'(fail_cnt_a), 32'd0);
        check_val("sA5_addr0", 32'(mem_a[0]), 32'hA5);
        check_val("sA5_addr1", 32'(mem_a[1]), 32'h4A);
        run_a(8'h00, nb);
        check_val("s00_busy_cycles", 32'(nb), 32'd33);
        check_val("s00_pass",  32'(pass_a),   32'd1);
        check_val("s00_addr0", 32'(mem_a[0]), 32'h01);
        check_val("s00_addr4", 32'(mem_a[4]), 32'h11);

        // Saturating fail counter on DUT B
        @(negedge clk);
        seed_b  = 8'h01;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        nb = 0;
        for (int g = 0; g < 400 && !done_b; g++) begin
            if (busy_b) nb++;
            @(negedge clk);
        end
        check_val("sat_done",        32'(done_b),      32'd1);
        check_val("sat_busy_cycles", 32'(nb),          32'd65);
        check_val("sat_fail_cnt",    32'(fail_cnt_b),  32'd15);
        check_val("sat_fail_addr",   32'(fail_addr_b), 32'd0);
        check_val("sat_pass",        32'(pass_b),      32'd0);

        // start mid-WRITE is ignored, reset mid-READ aborts
        @(negedge clk);
        seed_a  = 8'h01;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (k == 5) begin
                seed_a  = 8'h77;
                start_a = 1'b1;
            end else begin
                start_a = 1'b0;
            end
            if (k == 6) begin
                check_val("mid_start_addr", 32'(mem_addr_a), 32'd6);
                check_val("mid_start_we",   32'(mem_we_a),   32'd1);
            end
            @(negedge clk);
        end
        start_a = 1'b0;
        check_val("mid_read_cs",   32'(mem_cs_a),   32'd1);
        check_val("mid_read_we",   32'(mem_we_a),   32'd0);
        check_val("mid_read_addr", 32'(mem_addr_a), 32'd4);
        check_val("mid_wdata6",    32'(mem_a[6]),   32'h47);
        check_val("mid_wdata7",    32'(mem_a[7]),   32'h8E);
        rstn = 1'b0;
        #1;
        check_val("abort_busy", 32'(busy_a), 32'd0);
        check_val("abort_outs", 32'({done_a, pass_a, fail_addr_a, fail_cnt_a}), 32'd0);
        check_val("abort_mem",  32'({mem_cs_a, mem_we_a, mem_addr_a, mem_wdata_a}), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        run_a(8'h01, nb);
        check_val("clean_busy_cycles", 32'(nb), 32'd33);
        check_val("clean_pass",     32'(pass_a),     32'd1);
        check_val("clean_fail_cnt", 32'(fail_cnt_a), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
